// File: rtl/bp_cce_mode_sync_ctrl_if.sv
// rtl/bp_cce_mode_sync_ctrl_if.sv - sync-command / sync-ack bundle for the CCE mode controller
//
// Signals:
//   lce_cmd_v          master->slave  sync command valid
//   lce_cmd_ready_and  slave->master  sync command accepted (ready&valid)
//   lce_cmd_dst_id     master->slave  destination LCE of the sync command
//   lce_cmd_src_id     master->slave  issuing CCE id
//   sync_ack_v         slave->master  one sync ack returned this cycle
// Modports: master (the mode controller), slave (the LCE-side network).

interface bp_cce_mode_sync_ctrl_if #(
    parameter int lce_id_width_p = 4,
    parameter int cce_id_width_p = 4
);
    logic                      lce_cmd_v;
    logic                      lce_cmd_ready_and;
    logic [lce_id_width_p-1:0] lce_cmd_dst_id;
    logic [cce_id_width_p-1:0] lce_cmd_src_id;
    logic                      sync_ack_v;

    modport master (
        output lce_cmd_v,
        input  lce_cmd_ready_and,
        output lce_cmd_dst_id,
        output lce_cmd_src_id,
        input  sync_ack_v
    );

    modport slave (
        input  lce_cmd_v,
        output lce_cmd_ready_and,
        input  lce_cmd_dst_id,
        input  lce_cmd_src_id,
        output sync_ack_v
    );
endinterface

// File: rtl/bp_cce_mode_sync_ctrl.sv
// rtl/bp_cce_mode_sync_ctrl.sv - CCE uncached/normal mode switch with drain and LCE sync
//
// Switching to normal mode drains the CCE pipes, sends one sync command to each
// active LCE (throttled by max_outstanding_p unacked commands) and commits the
// mode once every sync has been acked. Switching to uncached mode only drains.
//
// Optional feature macro: BP_CCE_SYNC_TIMEOUT_EN (sync-ack timeout -> e_error).
//
// Ports:
//   clk_i, reset_n_i           clock, asynchronous active-low reset
//   cfg_mode_i                 requested mode (0 uncached, 1 normal)
//   cfg_cce_id_i               this CCE's id (sync command source)
//   cfg_num_active_lce_i       number of LCEs to sync, clamped to num_lce_p
//   req_empty_i .. mem_credits_full_i   drain status
//   cmd_if                     sync command / ack bundle (master side)
//   mode_o                     committed mode
//   drain_then_stall_o         stall request to the CCE pipes
//   busy_o                     controller not idle
//   timeout_o                  sticky sync-ack timeout

module bp_cce_mode_sync_ctrl #(
    parameter int num_lce_p         = 8,
    parameter int lce_id_width_p    = 4,
    parameter int cce_id_width_p    = 4,
    parameter int max_outstanding_p = 4,
    parameter int timeout_cycles_p  = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      cfg_mode_i,
    input  logic [cce_id_width_p-1:0] cfg_cce_id_i,
    input  logic [lce_id_width_p:0]   cfg_num_active_lce_i,
    input  logic                      req_empty_i,
    input  logic                      uc_pipe_empty_i,
    input  logic                      coh_pipe_empty_i,
    input  logic                      mem_credits_full_i,
    bp_cce_mode_sync_ctrl_if.master   cmd_if,
    output logic                      mode_o,
    output logic                      drain_then_stall_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int cnt_w_lp = $clog2(num_lce_p + 1);
    localparam logic [cnt_w_lp-1:0]     max_out_lp = cnt_w_lp'(max_outstanding_p);
    localparam logic [lce_id_width_p:0] num_lce_lp = (lce_id_width_p + 1)'(num_lce_p);

    typedef enum logic [2:0] {
        e_ready,
        e_wait_drain,
        e_send_sync,
        e_sync_ack,
        e_error
    } state_e;

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  stall_q, stall_d;
    logic                  busy_q, busy_d;
    logic                  cmd_v_q, cmd_v_d;
    logic [cnt_w_lp-1:0]   sent_q, sent_d;
    logic [cnt_w_lp-1:0]   out_q, out_d;
    logic [cnt_w_lp-1:0]   active_q, active_d;
    logic [cnt_w_lp-1:0]   active_clamp;
    logic                  hs;
    logic                  ack;
    logic                  drain_complete;

`ifdef BP_CCE_SYNC_TIMEOUT_EN
    localparam int tmr_w_lp = $clog2(timeout_cycles_p + 1);
    localparam logic [tmr_w_lp-1:0] tmr_max_lp = tmr_w_lp'(timeout_cycles_p);

    logic [tmr_w_lp-1:0]   timer_q, timer_d;
    logic                  timeout_q, timeout_d;
`endif

    assign hs  = cmd_v_q & cmd_if.lce_cmd_ready_and;
    assign ack = cmd_if.sync_ack_v;

    assign drain_complete = stall_q & req_empty_i & uc_pipe_empty_i
                          & coh_pipe_empty_i & mem_credits_full_i;

    assign active_clamp = (cfg_num_active_lce_i > num_lce_lp) ? cnt_w_lp'(num_lce_p)
                                                              : cnt_w_lp'(cfg_num_active_lce_i);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        stall_d  = stall_q;
        cmd_v_d  = cmd_v_q;
        sent_d   = sent_q;
        out_d    = out_q;
        active_d = active_q;
`ifdef BP_CCE_SYNC_TIMEOUT_EN
        timer_d   = '0;
        timeout_d = timeout_q;
`endif

        // Outstanding tracks handshakes minus acks; a simultaneous pair cancels
        // and a stray ack with nothing outstanding is dropped (no wrap below 0).
        if (hs && !ack) begin
            out_d = out_q + 1'b1;
        end else if (!hs && ack && (out_q != '0)) begin
            out_d = out_q - 1'b1;
        end

        case (state_q)
            e_ready: begin
                // Level compare, not edge: a pending mismatch is re-evaluated here
                // after any sync sequence finishes.
                if (cfg_mode_i != mode_q) begin
                    stall_d = 1'b1;
                    state_d = e_wait_drain;
                end
            end

            e_wait_drain: begin
                if (drain_complete) begin
                    if (cfg_mode_i == mode_q) begin
                        stall_d = 1'b0;
                        state_d = e_ready;
                    end else if (!cfg_mode_i) begin
                        mode_d  = 1'b0;
                        stall_d = 1'b0;
                        state_d = e_ready;
                    end else if (active_clamp == '0) begin
                        mode_d  = 1'b1;
                        stall_d = 1'b0;
                        state_d = e_ready;
                    end else begin
                        active_d = active_clamp;
                        sent_d   = '0;
                        state_d  = e_send_sync;
                        cmd_v_d  = (out_d < max_out_lp);
                    end
                end
            end

            e_send_sync: begin
                if (hs) begin
                    sent_d = sent_q + 1'b1;
                end
                if (hs && (sent_q == active_q - 1'b1)) begin
                    state_d = e_sync_ack;
                    cmd_v_d = 1'b0;
                end else begin
                    cmd_v_d = (out_d < max_out_lp);
                end
            end

            e_sync_ack: begin
                if ((out_q == '0) || ((out_q == cnt_w_lp'(1)) && ack)) begin
                    mode_d  = 1'b1;
                    stall_d = 1'b0;
                    state_d = e_ready;
                end
            end

            e_error: begin
                stall_d = 1'b1;
                cmd_v_d = 1'b0;
            end

            default: begin
                state_d = e_ready;
            end
        endcase

`ifdef BP_CCE_SYNC_TIMEOUT_EN
        // Idle-cycle counter: any forward progress (send or ack) restarts it.
        if ((state_q == e_send_sync) || (state_q == e_sync_ack)) begin
            if (hs || ack) begin
                timer_d = '0;
            end else if (out_q != '0) begin
                timer_d = timer_q + 1'b1;
            end else begin
                timer_d = timer_q;
            end
            if (timer_d == tmr_max_lp) begin
                state_d   = e_error;
                timeout_d = 1'b1;
                stall_d   = 1'b1;
                cmd_v_d   = 1'b0;
            end
        end
`endif
    end

    assign busy_d = (state_d != e_ready);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_ready;
            mode_q    <= 1'b0;
            stall_q   <= 1'b0;
            busy_q    <= 1'b0;
            cmd_v_q   <= 1'b0;
            sent_q    <= '0;
            out_q     <= '0;
            active_q  <= '0;
`ifdef BP_CCE_SYNC_TIMEOUT_EN
            timer_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            stall_q   <= stall_d;
            busy_q    <= busy_d;
            cmd_v_q   <= cmd_v_d;
            sent_q    <= sent_d;
            out_q     <= out_d;
            active_q  <= active_d;
`ifdef BP_CCE_SYNC_TIMEOUT_EN
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign cmd_if.lce_cmd_v      = cmd_v_q;
    assign cmd_if.lce_cmd_dst_id = lce_id_width_p'(sent_q);
    assign cmd_if.lce_cmd_src_id = cfg_cce_id_i;

    assign mode_o             = mode_q;
    assign drain_then_stall_o = stall_q;
    assign busy_o             = busy_q;

`ifdef BP_CCE_SYNC_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_cce_mode_sync_ctrl.sv
// tb/tb_bp_cce_mode_sync_ctrl.sv - directed self-checking bench for bp_cce_mode_sync_ctrl

module tb_bp_cce_mode_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_mode;
    logic [3:0] cfg_cce_id;
    logic [4:0] cfg_num;
    logic       req_empty, uc_empty, coh_empty, mem_full;
    logic       ready;
    logic       manual_ack;
    logic       auto_ack;
    logic [2:0] ack_pipe = 3'b000;
    logic       mode, stall, busy, timeout;

    logic [3:0] log_dst [0:63];
    logic [3:0] log_src [0:63];
    int         hs_cnt = 0;

    int n_total = 0;
    int n_pass  = 0;
    int base;
    bit held_ok;

    bp_cce_mode_sync_ctrl_if #(.lce_id_width_p(4), .cce_id_width_p(4)) bus ();

    assign bus.lce_cmd_ready_and = ready;
    assign bus.sync_ack_v        = manual_ack | ack_pipe[2];

    bp_cce_mode_sync_ctrl #(
        .num_lce_p         (8),
        .lce_id_width_p    (4),
        .cce_id_width_p    (4),
        .max_outstanding_p (2),
        .timeout_cycles_p  (16)
    ) dut (
        .clk_i                (clk),
        .reset_n_i            (rst_n),
        .cfg_mode_i           (cfg_mode),
        .cfg_cce_id_i         (cfg_cce_id),
        .cfg_num_active_lce_i (cfg_num),
        .req_empty_i          (req_empty),
        .uc_pipe_empty_i      (uc_empty),
        .coh_pipe_empty_i     (coh_empty),
        .mem_credits_full_i   (mem_full),
        .cmd_if               (bus),
        .mode_o               (mode),
        .drain_then_stall_o   (stall),
        .busy_o               (busy),
        .timeout_o            (timeout)
    );

    always #5 clk = ~clk;

    // Handshake logger and optional auto-ack three cycles after each send.
    always @(posedge clk) begin
        if (bus.lce_cmd_v && bus.lce_cmd_ready_and) begin
            if (hs_cnt < 64) begin
                log_dst[hs_cnt] <= bus.lce_cmd_dst_id;
                log_src[hs_cnt] <= bus.lce_cmd_src_id;
            end
            hs_cnt <= hs_cnt + 1;
        end
        ack_pipe <= {ack_pipe[1:0], auto_ack & bus.lce_cmd_v & bus.lce_cmd_ready_and};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_mode(input logic m, input string tag);
        int k = 0;
        while (mode !== m && k < 200) begin
            step(1);
            k++;
        end
        chk(tag, mode, m);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        cfg_mode   = 1'b0;
        cfg_cce_id = 4'hA;
        cfg_num    = 5'd0;
        req_empty  = 1'b1;
        uc_empty   = 1'b1;
        coh_empty  = 1'b1;
        mem_full   = 1'b1;
        ready      = 1'b1;
        manual_ack = 1'b0;
        auto_ack   = 1'b0;

        // Reset state
        step(2);
        chk("rst_mode", mode, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_cmd_v", bus.lce_cmd_v, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        rst_n = 1'b1;
        step(1);

        // Normal mode, 4 LCEs, acks 3 cycles after each send
        base     = hs_cnt;
        auto_ack = 1'b1;
        cfg_num  = 5'd4;
        cfg_mode = 1'b1;
        step(1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_stall", stall, 1'b1);
        wait_mode(1'b1, "t1_mode_commit");
        chk("t1_sync_count", hs_cnt - base, 4);
        for (int i = 0; i < 4; i++) chk("t1_dst", log_dst[base + i], i);
        chk("t1_src", log_src[base], 4'hA);
        chk("t1_stall_clear", stall, 1'b0);
        chk("t1_idle", busy, 1'b0);
        auto_ack = 1'b0;

        // Switch to uncached with coh pipe busy for 10 cycles
        base      = hs_cnt;
        cfg_mode  = 1'b0;
        coh_empty = 1'b0;
        step(1);
        chk("t2_stall_set", stall, 1'b1);
        held_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (stall !== 1'b1 || mode !== 1'b1) held_ok = 1'b0;
        end
        chk("t2_stall_held", held_ok, 1'b1);
        coh_empty = 1'b1;
        step(1);
        chk("t2_mode", mode, 1'b0);
        chk("t2_stall_clear", stall, 1'b0);
        chk("t2_idle", busy, 1'b0);
        chk("t2_no_sync", hs_cnt - base, 0);

        // Stray acks while idle must not corrupt the outstanding count
        manual_ack = 1'b1;
        step(2);
        manual_ack = 1'b0;

        // Throttling at max_outstanding = 2 with acks withheld
        base     = hs_cnt;
        cfg_num  = 5'd8;
        cfg_mode = 1'b1;
        step(12);
        chk("t3_two_issued", hs_cnt - base, 2);
        chk("t3_last_dst", log_dst[base + 1], 1);
        chk("t3_v_stalled", bus.lce_cmd_v, 1'b0);
        manual_ack = 1'b1;
        step(1);
        manual_ack = 1'b0;
        chk("t3_v_after_ack", bus.lce_cmd_v, 1'b1);
        chk("t3_dst_after_ack", bus.lce_cmd_dst_id, 4'd2);
        manual_ack = 1'b1;
        wait_mode(1'b1, "t3_mode_commit");
        manual_ack = 1'b0;
        chk("t3_sync_count", hs_cnt - base, 8);
        chk("t3_final_dst", log_dst[base + 7], 7);

        // Zero active LCEs: immediate commit after drain
        cfg_mode = 1'b0;
        wait_mode(1'b0, "t4_back_uc");
        base     = hs_cnt;
        cfg_num  = 5'd0;
        cfg_mode = 1'b1;
        step(1);
        chk("t4_not_yet", mode, 1'b0);
        step(1);
        chk("t4_mode", mode, 1'b1);
        chk("t4_stall_clear", stall, 1'b0);
        chk("t4_no_sync", hs_cnt - base, 0);

        // 12 requested LCEs clamp to num_lce_p = 8
        cfg_mode = 1'b0;
        wait_mode(1'b0, "t5_back_uc");
        base     = hs_cnt;
        cfg_num  = 5'd12;
        auto_ack = 1'b1;
        cfg_mode = 1'b1;
        wait_mode(1'b1, "t5_mode_commit");
        auto_ack = 1'b0;
        chk("t5_sync_count", hs_cnt - base, 8);
        chk("t5_final_dst", log_dst[base + 7], 7);

        // Send and ack in the same cycle leave outstanding unchanged
        cfg_mode = 1'b0;
        wait_mode(1'b0, "t6_back_uc");
        base     = hs_cnt;
        cfg_num  = 5'd8;
        cfg_mode = 1'b1;
        step(2);
        chk("t6_v_first", bus.lce_cmd_v, 1'b1);
        chk("t6_dst0", bus.lce_cmd_dst_id, 4'd0);
        step(1);
        chk("t6_dst1", bus.lce_cmd_dst_id, 4'd1);
        manual_ack = 1'b1;
        step(1);
        manual_ack = 1'b0;
        chk("t6_v_kept", bus.lce_cmd_v, 1'b1);
        chk("t6_dst2", bus.lce_cmd_dst_id, 4'd2);
        step(1);
        chk("t6_v_throttled", bus.lce_cmd_v, 1'b0);
        manual_ack = 1'b1;
        wait_mode(1'b1, "t6_mode_commit");
        manual_ack = 1'b0;
        chk("t6_sync_count", hs_cnt - base, 8);

        // Asynchronous reset from normal mode, sampled between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mode", mode, 1'b0);
        chk("arst_stall", stall, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_cmd_v", bus.lce_cmd_v, 1'b0);
        cfg_mode = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);

`ifdef BP_CCE_SYNC_TIMEOUT_EN
        // One LCE, its ack never arrives: timeout after 16 idle cycles
        cfg_num  = 5'd1;
        cfg_mode = 1'b1;
        step(3);
        chk("to_busy", busy, 1'b1);
        chk("to_v_done", bus.lce_cmd_v, 1'b0);
        step(15);
        chk("to_not_yet", timeout, 1'b0);
        step(1);
        chk("to_flag", timeout, 1'b1);
        chk("to_stall", stall, 1'b1);
        chk("to_cmd_v", bus.lce_cmd_v, 1'b0);
        cfg_mode = 1'b0;
        step(3);
        chk("to_stall_held", stall, 1'b1);
        chk("to_flag_sticky", timeout, 1'b1);
        rst_n = 1'b0;
        step(1);
        chk("to_rst_flag", timeout, 1'b0);
        chk("to_rst_stall", stall, 1'b0);
        chk("to_rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        step(1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
